mem_access_arbiter: RTL and testbench
=====================================

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: cycles a pending DMA request may be blocked by the CPU before it is forced through; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 cpu_rd  input  1  MEM-stage load request (MemRead).
REQ-005 cpu_wr  input  1  MEM-stage store request (MemWrite).
REQ-006 cpu_addr  input  32  MEM-stage byte address (ALU result).
REQ-007 cpu_wdata  input  32  MEM-stage store data (databus B).
REQ-008 cpu_rdata  output  32  load data to MEM/WB; combinational copy of mem_rdata.
REQ-009 cpu_stall  output  1  freeze PC/IF/ID/EX/MEM and insert a bubble into MEM/WB this cycle.
REQ-010 dma_req  input  1  DMA/loader access request, held until granted.
REQ-011 dma_we  input  1  1 = write, 0 = read; valid while dma_req = 1.
REQ-012 dma_addr  input  32  DMA byte address.
REQ-013 dma_wdata  input  32  DMA write data.
REQ-014 dma_gnt  output  1  DMA access performed this cycle; combinational.
REQ-015 dma_rdata  output  32  registered DMA read data.
REQ-016 dma_rvalid  output  1  one-cycle pulse: dma_rdata valid.
REQ-017 mem_addr, mem_wdata  output  32 each  muxed address and write data to DataMemory.
REQ-018 mem_rd, mem_wr  output  1 each  muxed MemRead/MemWrite to DataMemory.
REQ-019 mem_rdata  input  32  DataMemory read data (combinational read; write on rising clk).

Function
REQ-020 cpu_req = cpu_rd | cpu_wr; at most one requester is granted per cycle; one grant = one complete single-cycle access.
REQ-021 Default priority: CPU; with cpu_req = 1 and dma_wait < MAX_WAIT, the CPU is granted and dma_gnt = 0.
REQ-022 DMA is granted when dma_req = 1 and (cpu_req = 0 or dma_wait = MAX_WAIT).
REQ-023 dma_wait is a 4-bit counter: +1 on each cycle with dma_req = 1 and dma_gnt = 0, saturating at MAX_WAIT; cleared on any cycle with dma_gnt = 1 or dma_req = 0.
REQ-024 cpu_stall = cpu_req & dma_gnt; a stalled CPU access is retried unchanged next cycle and SHALL then win, since dma_wait is 0.
REQ-025 CPU grant: mem_addr/mem_wdata/mem_rd/mem_wr = cpu_addr/cpu_wdata/cpu_rd/cpu_wr.
REQ-026 DMA grant: mem_addr = dma_addr, mem_wdata = dma_wdata, mem_wr = dma_we, mem_rd = ~dma_we.
REQ-027 No grant: mem_rd = mem_wr = 0; mem_addr and mem_wdata = 0.
REQ-028 DMA read grant in cycle N: dma_rdata <= mem_rdata and dma_rvalid = 1 in cycle N+1 only; dma_rdata holds its value until the next DMA read.
REQ-029 cpu_rd and cpu_wr both 1: treated as a write (mem_rd = 0, mem_wr = 1).
REQ-030 Back-to-back DMA requests with the CPU idle: granted every cycle; dma_rvalid may stay high on consecutive cycles.

Reset
REQ-031 While reset = 0 at a rising edge: dma_wait = 0, dma_rvalid = 0, dma_rdata = 0; while reset = 0, dma_gnt = 0, cpu_stall = 0, mem_rd = mem_wr = 0.
REQ-032 A DMA read granted in the cycle when reset is asserted produces no dma_rvalid pulse.

Structure
REQ-033 A shared package holds MAX_WAIT_DEFAULT = 4, the 4-bit wait-counter width and the grant-select encoding (NONE, CPU, DMA).
REQ-034 Single flat module; the grant decision is purely combinational from cpu_req, dma_req and dma_wait; no sub-modules.

Verification
REQ-035 CPU lw 0x10 alone, mem_rdata = 0xDEADBEEF -> mem_rd = 1, mem_addr = 0x10, cpu_rdata = 0xDEADBEEF the same cycle, cpu_stall = 0.
REQ-036 DMA write 0x20 := 0x12345678, CPU idle -> dma_gnt = 1, mem_wr = 1, mem_wdata = 0x12345678 the same cycle.
REQ-037 CPU requests every cycle, dma_req held, MAX_WAIT = 4 -> dma_gnt = 0 for 4 cycles, then dma_gnt = 1 and cpu_stall = 1 for one cycle, then CPU granted.
REQ-038 DMA read 0x40, mem_rdata = 0xA5A5A5A5 -> next cycle dma_rvalid = 1, dma_rdata = 0xA5A5A5A5; the cycle after, dma_rvalid = 0.
REQ-039 reset = 0 asserted during a DMA read grant with dma_wait = 3 -> next cycle dma_rvalid = 0, dma_wait = 0, dma_rdata = 0.
REQ-040 cpu_rd = cpu_wr = 1 at 0x8 -> mem_wr = 1, mem_rd = 0.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter_pkg
// Description : Shared constants and grant-select encoding for the data-memory
//               port arbiter between the CPU MEM stage and a DMA/loader agent.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_arbiter_pkg;

    // Default number of cycles a DMA request may be held off by the CPU.
    localparam int MAX_WAIT_DEFAULT = 4;

    // Width of the DMA starvation counter (covers MAX_WAIT up to 15).
    localparam int WAIT_W = 4;

    // Which requester owns the memory port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_sel_e;

endpackage : mem_access_arbiter_pkg
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter
// Description : Single-port data-memory arbiter. The CPU has priority; a DMA
//               request blocked for MAX_WAIT cycles is forced through, stalling
//               the CPU for one cycle. DMA read data is registered and flagged
//               with a one-cycle valid pulse.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic              w_cpu_req;
    gnt_sel_e          w_sel;

    logic [WAIT_W-1:0] dma_wait_q;
    logic [WAIT_W-1:0] dma_wait_d;
    logic              dma_rvalid_q;
    logic              dma_rvalid_d;
    logic [31:0]       dma_rdata_q;
    logic [31:0]       dma_rdata_d;

    assign w_cpu_req = cpu_rd | cpu_wr;

    // Grant decision: DMA wins only when the CPU is idle or the DMA has starved
    // for MAX_WAIT cycles; nothing is granted while reset is held low.
    always_comb begin
        w_sel = GNT_NONE;
        if (reset) begin
            if (dma_req && (!w_cpu_req || (dma_wait_q == c_MAX_WAIT))) begin
                w_sel = GNT_DMA;
            end else if (w_cpu_req) begin
                w_sel = GNT_CPU;
            end
        end
    end

    // Memory-port mux and handshake outputs driven from the grant select.
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        dma_gnt   = 1'b0;
        case (w_sel)
            GNT_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                // A simultaneous read+write request is handled as a store.
                mem_rd    = cpu_rd & ~cpu_wr;
                mem_wr    = cpu_wr;
            end
            GNT_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_rd    = ~dma_we;
                mem_wr    = dma_we;
                dma_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_stall = w_cpu_req & dma_gnt;
    assign cpu_rdata = mem_rdata;

    // Next-state for the starvation counter and the DMA read-return register.
    always_comb begin
        dma_wait_d = '0;
        if (dma_req && !dma_gnt) begin
            dma_wait_d = (dma_wait_q == c_MAX_WAIT) ? dma_wait_q
                                                    : dma_wait_q + 1'b1;
        end
        dma_rvalid_d = dma_gnt & ~dma_we;
        dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dma_wait_q   <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= 32'd0;
        end else begin
            dma_wait_q   <= dma_wait_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

endmodule : mem_access_arbiter
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_arbiter
// Description : Self-checking bench for mem_access_arbiter: directed scenarios
//               plus randomized traffic against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_arbiter;

    localparam int MAXW = 4;

    logic        clk;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_wait;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    // Reference model combinational expectations
    logic        e_dgnt, e_stall, e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;

    mem_access_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rdata (dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected port behaviour for the current inputs, from the arbitration rules.
    task automatic model_comb();
        logic creq;
        creq    = cpu_rd | cpu_wr;
        e_dgnt  = reset && dma_req && (!creq || m_wait >= MAXW);
        e_stall = creq && e_dgnt;
        e_addr  = 32'd0; e_wdata = 32'd0; e_rd = 1'b0; e_wr = 1'b0;
        if (e_dgnt) begin
            e_addr = dma_addr; e_wdata = dma_wdata; e_wr = dma_we; e_rd = !dma_we;
        end else if (reset && creq) begin
            e_addr = cpu_addr; e_wdata = cpu_wdata; e_wr = cpu_wr; e_rd = cpu_rd && !cpu_wr;
        end
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int          n_wait;
        logic        n_rvalid;
        logic [31:0] n_rdata;
        model_comb();
        if (!reset) begin
            n_wait = 0; n_rvalid = 1'b0; n_rdata = 32'd0;
        end else begin
            n_rvalid = e_dgnt && !dma_we;
            n_rdata  = n_rvalid ? mem_rdata : m_rdata;
            n_wait   = (dma_req && !e_dgnt) ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
        end
        @(posedge clk);
        m_wait = n_wait; m_rvalid = n_rvalid; m_rdata = n_rdata;
        #1;
    endtask

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        cpu_rd = 1; cpu_addr = 32'h44; dma_req = 1; dma_we = 0; dma_addr = 32'h88;
        tick(); tick();
        @(negedge clk);
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt: got=%b exp=0", dma_gnt); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got=%b exp=0", cpu_stall); end
        total++; if ({mem_rd, mem_wr} !== 2'b00) begin bad++; $display("FAIL rst_rdwr: got=%b exp=00", {mem_rd, mem_wr}); end
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got=%b exp=0", dma_rvalid); end
        total++; if (dma_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got=%h exp=0", dma_rdata); end
        idle_inputs();
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_cpu_load();
        cpu_rd = 1; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0) begin bad++; $display("FAIL lw_rdwr: got=%b%b exp=10", mem_rd, mem_wr); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL lw_addr: got=%h exp=10", mem_addr); end
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got=%h exp=deadbeef", cpu_rdata); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL lw_stall: got=%b exp=0", cpu_stall); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_dma_write();
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL dw_gnt: got=%b exp=1", dma_gnt); end
        total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin bad++; $display("FAIL dw_rdwr: got=%b%b exp=01", mem_rd, mem_wr); end
        total++; if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h20) begin bad++; $display("FAIL dw_data: got=%h@%h exp=12345678@20", mem_wdata, mem_addr); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL dw_norvalid: got=%b exp=0", dma_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        cpu_rd = 1; cpu_addr = 32'h100; dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        for (int i = 0; i < MAXW; i++) begin
            @(negedge clk);
            total++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL starve_hold%0d: got=%b%b exp=00", i, dma_gnt, cpu_stall); end
            total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL starve_cpuaddr%0d: got=%h exp=100", i, mem_addr); end
            tick();
        end
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1) begin bad++; $display("FAIL starve_force: got=%b%b exp=11", dma_gnt, cpu_stall); end
        total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL starve_dmaaddr: got=%h exp=200", mem_addr); end
        tick();
        @(negedge clk);
        total++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'h100) begin bad++; $display("FAIL starve_cpuwins: got=%b%b %h exp=00 100", dma_gnt, cpu_stall, mem_addr); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_dma_read();
        dma_req = 1; dma_we = 0; dma_addr = 32'h40; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1 || mem_rd !== 1'b1) begin bad++; $display("FAIL dr_gnt: got=%b%b exp=11", dma_gnt, mem_rd); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL dr_rvalid: got=%b exp=1", dma_rvalid); end
        total++; if (dma_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL dr_rdata: got=%h exp=a5a5a5a5", dma_rdata); end
        tick();
        @(negedge clk);
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL dr_pulse: got=%b exp=0", dma_rvalid); end
        total++; if (dma_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL dr_hold: got=%h exp=a5a5a5a5", dma_rdata); end
        tick();
    endtask

    task automatic test_reset_during_read();
        cpu_rd = 1; cpu_addr = 32'h300; dma_req = 1; dma_we = 0; dma_addr = 32'h40;
        repeat (3) tick();
        cpu_rd = 0; reset = 0; mem_rdata = 32'h11112222;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rr_gnt: got=%b exp=0", dma_gnt); end
        tick();
        reset = 1; dma_req = 0;
        @(negedge clk);
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rr_rvalid: got=%b exp=0", dma_rvalid); end
        total++; if (dma_rdata !== 32'd0) begin bad++; $display("FAIL rr_rdata: got=%h exp=0", dma_rdata); end
        tick();
        // Counter must restart from zero: a full MAX_WAIT blocked cycles again.
        cpu_rd = 1; dma_req = 1;
        for (int i = 0; i < MAXW; i++) begin
            @(negedge clk);
            total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rr_wait%0d: got=%b exp=0", i, dma_gnt); end
            tick();
        end
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL rr_force: got=%b exp=1", dma_gnt); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_rw_both();
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h8; cpu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin bad++; $display("FAIL rw_rdwr: got=%b%b exp=01", mem_rd, mem_wr); end
        total++; if (mem_addr !== 32'h8 || mem_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rw_data: got=%h@%h exp=cafef00d@8", mem_wdata, mem_addr); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        dma_req = 1; dma_we = 0;
        for (int i = 0; i < 4; i++) begin
            dma_addr = 32'h1000 + 32'(i * 4); mem_rdata = $urandom;
            @(negedge clk);
            total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt%0d: got=%b exp=1", i, dma_gnt); end
            if (i > 0) begin
                total++; if (dma_rvalid !== 1'b1 || dma_rdata !== prev) begin bad++; $display("FAIL b2b_rv%0d: got=%b %h exp=1 %h", i, dma_rvalid, dma_rdata, prev); end
            end
            prev = mem_rdata;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 29) != 0);
            cpu_rd    = ($urandom_range(0, 9) < 5);
            cpu_wr    = ($urandom_range(0, 9) < 3);
            cpu_addr  = $urandom; cpu_wdata = $urandom;
            dma_req   = ($urandom_range(0, 9) < 6);
            dma_we    = $urandom_range(0, 1);
            dma_addr  = $urandom; dma_wdata = $urandom; mem_rdata = $urandom;
            @(negedge clk);
            model_comb();
            total++; if (dma_gnt !== e_dgnt) begin bad++; $display("FAIL rnd_gnt@%0d: got=%b exp=%b", n, dma_gnt, e_dgnt); end
            total++; if (cpu_stall !== e_stall) begin bad++; $display("FAIL rnd_stall@%0d: got=%b exp=%b", n, cpu_stall, e_stall); end
            total++; if ({mem_rd, mem_wr} !== {e_rd, e_wr}) begin bad++; $display("FAIL rnd_rdwr@%0d: got=%b%b exp=%b%b", n, mem_rd, mem_wr, e_rd, e_wr); end
            total++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin bad++; $display("FAIL rnd_bus@%0d: got=%h/%h exp=%h/%h", n, mem_addr, mem_wdata, e_addr, e_wdata); end
            total++; if (cpu_rdata !== mem_rdata) begin bad++; $display("FAIL rnd_cpurdata@%0d: got=%h exp=%h", n, cpu_rdata, mem_rdata); end
            total++; if (dma_rvalid !== m_rvalid || dma_rdata !== m_rdata) begin bad++; $display("FAIL rnd_dmard@%0d: got=%b %h exp=%b %h", n, dma_rvalid, dma_rdata, m_rvalid, m_rdata); end
            tick();
        end
        idle_inputs();
        reset = 1;
        tick();
    endtask

    initial begin
        m_wait = 0; m_rvalid = 1'b0; m_rdata = 32'd0;
        idle_inputs();
        reset = 0;
        #1;
        test_reset();
        test_cpu_load();
        test_dma_write();
        test_starvation();
        test_dma_read();
        test_reset_during_read();
        test_rw_both();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_access_arbiter
`default_nettype wire
